// File: rtl/cla_pkg.sv
// Shared lookahead definitions for cla_adder4.
// Group width, group P/G bundle and the 4-bit carry function.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  // Flat sum-of-products carries c[0..4]; no ripple between bits.
  function automatic logic [4:0] cla_carries(
    input logic [3:0] p,
    input logic [3:0] g,
    input logic       c0
  );
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0]
         | (p[0] & c0);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla_adder4_group.sv
// One 4-bit carry-lookahead group.
// Exports group propagate/generate for the second-level lookahead.
module cla4_group
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       grp_p,
  output logic       grp_g,
  output logic       c_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;
  assign c = cla_carries(p, g, c_in);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];
  assign grp_p = &p;
  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder4.sv
// Registered carry-lookahead adder, WIDTH a multiple of 4.
// CLA_IN_REG_EN adds the input register stage (latency 2, else 1).
module cla_adder4
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = WIDTH / GROUP_W;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

`ifdef CLA_IN_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end
`else
  assign a_q   = a;
  assign b_q   = b;
  assign cin_q = cin;
`endif

  grp_pg_t [NG-1:0] pg;
  logic    [NG:0]   gc;
  logic    [NG-1:0] co;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             term;
  logic             unused_gc_top;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4_group u_grp (
      .a     (a_q[GROUP_W*k +: GROUP_W]),
      .b     (b_q[GROUP_W*k +: GROUP_W]),
      .c_in  (gc[k]),
      .sum   (s_d[GROUP_W*k +: GROUP_W]),
      .grp_p (pg[k].p),
      .grp_g (pg[k].g),
      .c_out (co[k])
    );
  end

  // Second-level lookahead: each group carry-in is a flat SOP of P/G.
  always_comb begin
    gc    = '0;
    term  = 1'b0;
    gc[0] = cin_q;
    for (int k = 0; k < NG; k++) begin
      term = cin_q;
      for (int m = 0; m <= k; m++) term = term & pg[m].p;
      gc[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = pg[j].g;
        for (int m = j + 1; m <= k; m++) term = term & pg[m].p;
        gc[k+1] = gc[k+1] | term;
      end
    end
  end

  assign cout_d        = co[NG-1];
  assign unused_gc_top = gc[NG];

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= s_d;
      cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla_adder4.sv
// Directed and exhaustive checks for cla_adder4 (WIDTH = 4).
// Latency follows the CLA_IN_REG_EN build option.
module tb_cla_adder4;

`ifdef CLA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;

  int checks = 0;
  int errors = 0;

  cla_adder4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] es,
                       input logic ec);
    checks++;
    if (s !== es || cout !== ec) begin
      errors++;
      $display("FAIL %s: got s=%b cout=%b, expected s=%b cout=%b",
               name, s, cout, es, ec);
    end
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
  endtask

  initial begin
    vecs[0] = '{"9+9",       4'b1001, 4'b1001, 1'b0, 4'b0010, 1'b1};
    vecs[1] = '{"c+3",       4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0};
    vecs[2] = '{"f+0+1",     4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[3] = '{"0+0",       4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{"7+1",       4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0};
    vecs[5] = '{"f+f+1",     4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[6] = '{"5+a+1",     4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1};
    vecs[7] = '{"6+3",       4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0};
    vecs[8] = '{"8+8",       4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};
    vecs[9] = '{"f+f+1 pre", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};

    rst = 1'b1;
    drive(4'b0, 4'b0, 1'b0);
    step();
    check("reset_c1", 4'b0000, 1'b0);
    step();
    check("reset_c2", 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    check("post_reset_e1", 4'b0000, 1'b0);
    step();
    check("post_reset_e2", 4'b0000, 1'b0);

    // Pipelined table; a junk value mid-cycle must not matter.
    for (int i = 0; i < 10 + LAT - 1; i++) begin
      if (i < 10) begin
        drive(~vecs[i].a, ~vecs[i].b, ~vecs[i].cin);
        #3;
        drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      end else begin
        drive(4'b0, 4'b0, 1'b0);
      end
      step();
      if (i >= LAT - 1)
        check(vecs[i-LAT+1].name, vecs[i-LAT+1].s, vecs[i-LAT+1].cout);
    end

    // Operand 7+1 followed by reset: its sum 1000 must never show.
    drive(4'b0111, 4'b0001, 1'b0);
    for (int i = 0; i < LAT - 1; i++) step();
    rst = 1'b1;
    step();
    check("flush_at_reset", 4'b0000, 1'b0);
    drive(4'b0, 4'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      check("flush_after_release", 4'b0000, 1'b0);
    end

    // Exhaustive back-to-back sweep of all 512 combinations.
    for (int i = 0; i < 512 + LAT - 1; i++) begin
      logic [8:0] v;
      logic [4:0] exp;
      if (i < 512) begin
        v = 9'(i);
        drive(v[8:5], v[4:1], v[0]);
      end else begin
        drive(4'b0, 4'b0, 1'b0);
      end
      step();
      if (i >= LAT - 1) begin
        v   = 9'(i - LAT + 1);
        exp = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
        check($sformatf("sweep_%0d", i - LAT + 1), exp[3:0], exp[4]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
